// File: rtl/pcseq_pkg.sv
// Shared definitions for the program-sequencing unit: pc_op encoding and widths.
package pcseq_pkg;

    localparam int unsigned PCSEQ_OP_W = 3;

    typedef enum logic [PCSEQ_OP_W-1:0] {
        OP_INC  = 3'b000,
        OP_JMP  = 3'b001,
        OP_JREL = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100,
        OP_HOLD = 3'b101,
        OP_RETI = 3'b110,
        OP_EI   = 3'b111
    } pc_op_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit / program-memory side bundle of the sequencer.
interface pc_sequencer_if #(
    parameter int unsigned PC_W = 10
);
    import pcseq_pkg::*;

    logic [PCSEQ_OP_W-1:0] pc_op;
    logic [PC_W-1:0]       target;
    logic                  irq;
    logic [PC_W-1:0]       pc;
    logic                  irq_ack;
    logic                  ie;
    logic                  stack_overflow;
    logic                  stack_underflow;

    modport master (
        output pc_op, target, irq,
        input  pc, irq_ack, ie, stack_overflow, stack_underflow
    );

    modport slave (
        input  pc_op, target, irq,
        output pc, irq_ack, ie, stack_overflow, stack_underflow
    );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO. With PCSEQ_STACK_WRAP_EN defined a push on full
// overwrites the oldest entry instead of being discarded.
module ret_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned SP_W  = IDX_W + 1;

    logic [W-1:0]      r_mem [DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic [IDX_W-1:0]  r_wp;
    logic              w_wr_en;

    assign o_full  = (r_sp == SP_W'(DEPTH));
    assign o_empty = (r_sp == '0);
    assign o_top   = r_mem[r_wp - IDX_W'(1)];

`ifdef PCSEQ_STACK_WRAP_EN
    assign w_wr_en = i_push;
`else
    assign w_wr_en = i_push && !o_full;
`endif

    // Write pointer runs modulo DEPTH; sp counts valid entries and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
            r_wp <= '0;
        end else if (w_wr_en) begin
            r_wp <= r_wp + IDX_W'(1);
            if (!o_full) r_sp <= r_sp + SP_W'(1);
        end else if (i_pop && !o_empty) begin
            r_wp <= r_wp - IDX_W'(1);
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // Storage carries no reset; validity is tracked by r_sp alone.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wp] <= i_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: next-pc mux, call/return stack, single-level interrupt.
// PCSEQ_STACK_WRAP_EN selects the circular stack (no interrupt deferral on full).
module pc_sequencer
    import pcseq_pkg::*;
#(
    parameter int unsigned    PC_W        = 10,
    parameter int unsigned    STACK_DEPTH = 8,
    parameter logic [PC_W-1:0] IRQ_VECTOR = PC_W'(10'h3F0)
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    logic [PC_W-1:0] r_pc;
    logic            r_ie;
    logic            r_ovf;
    logic            r_unf;

    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_push_data;
    logic [PC_W-1:0] w_top;
    logic            w_ie_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_take;
    logic            w_unf_set;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef PCSEQ_STACK_WRAP_EN
    assign w_take = bus.irq && r_ie;
`else
    assign w_take = bus.irq && r_ie && !w_full;
`endif

    // Next-state selection; an accepted interrupt overrides pc_op entirely.
    always_comb begin
        w_pc_nxt    = r_pc + PC_W'(1);
        w_push_data = r_pc + PC_W'(1);
        w_ie_nxt    = r_ie;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_unf_set   = 1'b0;
        if (w_take) begin
            w_push      = 1'b1;
            w_push_data = r_pc;
            w_pc_nxt    = IRQ_VECTOR;
            w_ie_nxt    = 1'b0;
        end else begin
            case (pc_op_e'(bus.pc_op))
                OP_INC:  ;
                OP_JMP:  w_pc_nxt = bus.target;
                OP_JREL: w_pc_nxt = r_pc + bus.target;
                OP_CALL: begin
                    w_push   = 1'b1;
                    w_pc_nxt = bus.target;
                end
                OP_RET, OP_RETI: begin
                    if (w_empty) begin
                        w_unf_set = 1'b1;
                    end else begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_top;
                    end
                    if (pc_op_e'(bus.pc_op) == OP_RETI) w_ie_nxt = 1'b1;
                end
                OP_HOLD: w_pc_nxt = r_pc;
                OP_EI:   w_ie_nxt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= '0;
            r_ie  <= 1'b0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            r_ie <= w_ie_nxt;
            if (w_push && w_full) r_ovf <= 1'b1;
            if (w_unf_set)        r_unf <= 1'b1;
        end
    end

    assign bus.pc              = r_pc;
    assign bus.ie              = r_ie;
    assign bus.irq_ack         = w_take;
    assign bus.stack_overflow  = r_ovf;
    assign bus.stack_underflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default and PCSEQ_STACK_WRAP_EN builds).
module tb_pc_sequencer;
    import pcseq_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    pc_sequencer_if #(.PC_W(10)) bus ();

    pc_sequencer #(
        .PC_W        (10),
        .STACK_DEPTH (8),
        .IRQ_VECTOR  (10'h3F0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one op and return 1 time unit after the edge that executes it.
    task automatic step(input logic [2:0] op, input logic [9:0] t);
        bus.pc_op  = op;
        bus.target = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        reset      = 1'b0;
        bus.pc_op  = OP_INC;
        bus.target = '0;
        bus.irq    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",  32'(bus.pc), 32'h0);
        chk("rst_ie",  32'(bus.ie), 32'h0);
        chk("rst_ack", 32'(bus.irq_ack), 32'h0);
        chk("rst_ovf", 32'(bus.stack_overflow), 32'h0);
        chk("rst_unf", 32'(bus.stack_underflow), 32'h0);
        reset = 1'b1;

        step(OP_INC, '0);        chk("inc1", 32'(bus.pc), 32'h1);
        step(OP_INC, '0);        chk("inc2", 32'(bus.pc), 32'h2);
        step(OP_INC, '0);        chk("inc3", 32'(bus.pc), 32'h3);
        step(OP_JMP, 10'h100);   chk("jmp", 32'(bus.pc), 32'h100);
        step(OP_JREL, 10'h3FE);  chk("jrel_neg", 32'(bus.pc), 32'h0FE);
        step(OP_JMP, 10'h3FF);
        step(OP_INC, '0);        chk("inc_wrap", 32'(bus.pc), 32'h000);
        chk("wrap_ovf", 32'(bus.stack_overflow), 32'h0);
        chk("wrap_unf", 32'(bus.stack_underflow), 32'h0);

        // Nested call / return.
        step(OP_JMP, 10'h010);
        step(OP_CALL, 10'h200);  chk("call1", 32'(bus.pc), 32'h200);
        step(OP_CALL, 10'h300);  chk("call2", 32'(bus.pc), 32'h300);
        step(OP_RET, '0);        chk("ret1", 32'(bus.pc), 32'h201);
        step(OP_RET, '0);        chk("ret2", 32'(bus.pc), 32'h011);
        chk("ret_unf", 32'(bus.stack_underflow), 32'h0);

        // Interrupt entry and exit.
        step(OP_JMP, 10'h005);
        step(OP_EI, '0);         chk("ei_pc", 32'(bus.pc), 32'h6);
        chk("ei_ie", 32'(bus.ie), 32'h1);
        bus.irq = 1'b1;
        bus.pc_op = OP_INC;
        #1;
        chk("irq_ack_hi", 32'(bus.irq_ack), 32'h1);
        step(OP_INC, '0);        chk("irq_pc", 32'(bus.pc), 32'h3F0);
        chk("irq_ie", 32'(bus.ie), 32'h0);
        chk("irq_ack_masked", 32'(bus.irq_ack), 32'h0);
        step(OP_INC, '0);        chk("isr_inc", 32'(bus.pc), 32'h3F1);
        bus.irq = 1'b0;
        step(OP_RETI, '0);       chk("reti_pc", 32'(bus.pc), 32'h6);
        chk("reti_ie", 32'(bus.ie), 32'h1);

        // Fill the stack, then overflow it.
        for (int i = 0; i < 8; i++) step(OP_CALL, 10'(10'h040 + i));
        chk("fill_pc", 32'(bus.pc), 32'h047);
        chk("fill_ovf", 32'(bus.stack_overflow), 32'h0);
        step(OP_CALL, 10'h050);  chk("ovf_pc", 32'(bus.pc), 32'h050);
        chk("ovf_flag", 32'(bus.stack_overflow), 32'h1);

        bus.irq = 1'b1;
        bus.pc_op = OP_HOLD;
        #1;
`ifdef PCSEQ_STACK_WRAP_EN
        chk("full_irq_ack", 32'(bus.irq_ack), 32'h1);
        step(OP_HOLD, '0);       chk("full_irq_pc", 32'(bus.pc), 32'h3F0);
        bus.irq = 1'b0;
        step(OP_RETI, '0);       chk("wrap_reti", 32'(bus.pc), 32'h050);
        step(OP_RET, '0);        chk("wrap_ret", 32'(bus.pc), 32'h048);
`else
        chk("full_irq_defer", 32'(bus.irq_ack), 32'h0);
        step(OP_HOLD, '0);       chk("defer_hold", 32'(bus.pc), 32'h050);
        chk("defer_ack2", 32'(bus.irq_ack), 32'h0);
        step(OP_RET, '0);        chk("defer_ret", 32'(bus.pc), 32'h047);
        bus.pc_op = OP_HOLD;
        #1;
        chk("late_ack", 32'(bus.irq_ack), 32'h1);
        step(OP_HOLD, '0);       chk("late_irq_pc", 32'(bus.pc), 32'h3F0);
        bus.irq = 1'b0;
        step(OP_RETI, '0);       chk("late_reti", 32'(bus.pc), 32'h047);
`endif
        chk("ovf_sticky", 32'(bus.stack_overflow), 32'h1);

        // Asynchronous reset between edges.
        #3 reset = 1'b0;
        #1;
        chk("arst_pc", 32'(bus.pc), 32'h0);
        chk("arst_ie", 32'(bus.ie), 32'h0);
        chk("arst_ovf", 32'(bus.stack_overflow), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Underflow with an empty stack.
        step(OP_JMP, 10'h020);
        step(OP_RET, '0);        chk("unf_pc", 32'(bus.pc), 32'h021);
        chk("unf_flag", 32'(bus.stack_underflow), 32'h1);
        step(OP_RETI, '0);       chk("unf_reti_pc", 32'(bus.pc), 32'h022);
        chk("unf_reti_ie", 32'(bus.ie), 32'h1);
        step(OP_INC, '0);        chk("unf_sticky", 32'(bus.stack_underflow), 32'h1);

        #3 reset = 1'b0;
        #1;
        chk("arst2_pc", 32'(bus.pc), 32'h0);
        chk("arst2_ie", 32'(bus.ie), 32'h0);
        chk("arst2_unf", 32'(bus.stack_underflow), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        step(OP_RET, '0);        chk("post_rst_empty", 32'(bus.pc), 32'h1);
        chk("post_rst_unf", 32'(bus.stack_underflow), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-sequencing unit for the next-generation single-cycle core. It replaces the fixed 10-bit PC register, incrementer and jump muxes with one block. The block adds:
- absolute and relative jumps
- hardware call/return stack
- single-level interrupt entry/exit

It sits between the control unit (which supplies pc_op) and program memory (which is addressed by pc).

Parameters:
PC_W, 10, program counter and target width in bits
STACK_DEPTH, 8, return-stack entries (power of two, >=2)
IRQ_VECTOR, 10'h3F0, PC loaded on interrupt entry (PC_W bits)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
pc_op  in  3  sequencing operation for current instruction
target  in  PC_W  absolute address or signed offset, from instruction word
irq  in  1  level interrupt request
pc  out  PC_W  current program counter (program-memory address)
irq_ack  out  1  one-cycle pulse: interrupt taken this cycle; control unit must suppress we3/wez/memory writes
ie  out  1  interrupt-enable state
stack_overflow  out  1  sticky: push attempted on full stack
stack_underflow  out  1  sticky: pop attempted on empty stack

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=0, ie=0, irq_ack=0
  - sp=0 (stack empty)
  - both sticky flags=0
  - stack RAM contents undefined
- pc_op encoding (in shared package); all arithmetic modulo 2^PC_W, wrap silently:
  - 000 INC: pc<=pc+1
  - 001 JMP: pc<=target
  - 010 JREL: pc<=pc+target, target treated as two's-complement PC_W-bit
  - 011 CALL: push pc+1; pc<=target
  - 100 RET: pop top into pc
  - 101 HOLD: pc unchanged
  - 110 RETI: as RET, plus ie<=1
  - 111 EI: ie<=1; pc<=pc+1
- Latency: every op takes effect at the next edge; pc is purely registered, never combinational from pc_op.
- Interrupt take condition: irq=1 AND ie=1 AND stack not full, sampled at the edge.
- When an interrupt is taken:
  - pc_op is ignored
  - pc (not pc+1) is pushed, so the interrupted instruction re-executes after RETI
  - pc<=IRQ_VECTOR, ie<=0
  - irq_ack is high combinationally for that cycle only
- irq with ie=1 but stack full: interrupt deferred, not lost; pc_op executes normally.
- CALL on full stack: jump still taken, push discarded, stack_overflow<=1.
- RET/RETI on empty stack: pc<=pc+1, stack_underflow<=1. RETI still sets ie.
- Sticky flags clear only on reset.
- Stack is LIFO with sp in 0..STACK_DEPTH (width clog2(STACK_DEPTH)+1). Simultaneous push and pop in one cycle cannot occur.
- Reset asserted mid-operation: immediate return to reset state; no partial push survives.

Optional Feature:
PCSEQ_STACK_WRAP_EN
- Defined: stack is circular. Push on full overwrites the oldest entry, sp saturates at STACK_DEPTH, stack_overflow still sets. Interrupts are no longer deferred on full stack.
- Undefined: discard-on-full and interrupt deferral exactly as in Behaviour.

Decomposition:
- Shared package pcseq_pkg holds:
  - pc_op encoding constants (OP_INC…OP_EI)
  - PCSEQ_OP_W=3
- One sub-module: ret_stack (parametrised LIFO with push, pop, full, empty, data in/out, plus the wrap option).
- Next-pc mux and interrupt logic stay in pc_sequencer.

Test Plan:
- Reset, then INC x3 → pc=0,1,2,3; JMP target=0x100 → pc=0x100; JREL target=0x3FE (-2) → pc=0x0FE.
- pc=0x3FF, INC → pc=0x000, no flags set.
- CALL 0x200 at pc=0x010, CALL 0x300, RET, RET → pc=0x200, 0x300, 0x201, 0x011; sp back to 0.
- EI at pc=5, irq=1 next cycle at pc=6 → irq_ack pulse, pc=0x3F0, ie=0; RETI → pc=6, ie=1.
- 8 CALLs fill stack; 9th CALL to 0x050 → pc=0x050, stack_overflow=1. irq=1 with ie=1 → no ack until one RET frees an entry (wrap macro: ack immediately).
- RET on empty stack at pc=0x020 → pc=0x021, stack_underflow=1; assert reset mid-sequence → all outputs 0 asynchronously.
